// File: rtl/eth_irq_claim_gateway_if.sv
// Host-facing bundle of the interrupt claim gateway: generator pending levels
// and host claim/complete pulses in, interrupt request, claim response and
// TX pending-clear pulse out. No handshake; every pulse is a one-cycle strobe.
//   slave  : the gateway (consumes pending/claim/complete, drives irq/claim/clear)
//   master : the environment (generator + host)
interface eth_irq_claim_gateway_if;
  logic       rx_pending_i;
  logic       tx_pending_i;
  logic       claim_v_i;
  logic       complete_v_i;
  logic [1:0] complete_id_i;
  logic       irq_o;
  logic       claim_v_o;
  logic [1:0] claim_id_o;
  logic       tx_clear_o;

  modport slave (
    input  rx_pending_i, tx_pending_i, claim_v_i, complete_v_i, complete_id_i,
    output irq_o, claim_v_o, claim_id_o, tx_clear_o
  );

  modport master (
    output rx_pending_i, tx_pending_i, claim_v_i, complete_v_i, complete_id_i,
    input  irq_o, claim_v_o, claim_id_o, tx_clear_o
  );
endinterface

// File: rtl/eth_irq_claim_gateway.sv
// Purpose: claim/complete interrupt gateway for the Ethernet RX/TX pending lines.
// Latency: pending -> irq_o 1 cycle; claim -> registered response 1 cycle.
// Backpressure: none; claims with nothing pending answer id 0, bad completes drop.
// Ports: clk_i, reset_n_i (async, active-low), bus (eth_irq_claim_gateway_if.slave).
module eth_irq_claim_gateway #(
  parameter int holdoff_cycles_p = 16
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  eth_irq_claim_gateway_if.slave       bus
);

  localparam int CntW    = (holdoff_cycles_p < 1) ? 1 : $clog2(holdoff_cycles_p + 1);
  localparam int LoadInt = (holdoff_cycles_p > 0) ? holdoff_cycles_p - 1 : 0;
  localparam logic [CntW-1:0] HoldLoad = CntW'(LoadInt);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PEND    = 2'd1,
    S_CLAIMED = 2'd2,
    S_HOLD    = 2'd3
  } src_state_e;

  // Index 0 = RX (id 1), index 1 = TX (id 2).
  src_state_e      state_q [2];
  src_state_e      state_d [2];
  logic [CntW-1:0] cnt_q   [2];
  logic [CntW-1:0] cnt_d   [2];

  logic       last_tx_q, last_tx_d;   // 1: TX was granted most recently
  logic       claim_v_q, claim_v_d;
  logic [1:0] claim_id_q, claim_id_d;
  logic       tx_clear_q, tx_clear_d;

  logic [1:0] pend_in;
  logic [1:0] in_pend;
  logic [1:0] grant;

  assign pend_in = {bus.tx_pending_i, bus.rx_pending_i};
  assign in_pend = {state_q[1] == S_PEND, state_q[0] == S_PEND};

  // Arbitration looks only at registered states; on contention the source
  // that did not win last time is granted.
  always_comb begin
    grant = 2'b00;
    if (bus.claim_v_i) begin
      case (in_pend)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_tx_q ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        S_IDLE: begin
          if (pend_in[i]) state_d[i] = S_PEND;
        end
        S_PEND: begin
          // A grant wins over a same-cycle drop of the pending level.
          if (grant[i])        state_d[i] = S_CLAIMED;
          else if (!pend_in[i]) state_d[i] = S_IDLE;
        end
        S_CLAIMED: begin
          if (bus.complete_v_i && (bus.complete_id_i == 2'(i + 1))) begin
            if (holdoff_cycles_p == 0) begin
              state_d[i] = S_IDLE;
            end else begin
              state_d[i] = S_HOLD;
              cnt_d[i]   = HoldLoad;
            end
          end
        end
        S_HOLD: begin
          if (cnt_q[i] == '0) state_d[i] = S_IDLE;
          else                cnt_d[i]   = cnt_q[i] - CntW'(1);
        end
        default: state_d[i] = S_IDLE;
      endcase
    end

    claim_v_d  = bus.claim_v_i;
    claim_id_d = grant[0] ? 2'd1 : (grant[1] ? 2'd2 : 2'd0);
    tx_clear_d = grant[1];
    last_tx_d  = grant[1] ? 1'b1 : (grant[0] ? 1'b0 : last_tx_q);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q[0] <= S_IDLE;
      state_q[1] <= S_IDLE;
      cnt_q[0]   <= '0;
      cnt_q[1]   <= '0;
      last_tx_q  <= 1'b1;   // RX wins the first contention
      claim_v_q  <= 1'b0;
      claim_id_q <= 2'd0;
      tx_clear_q <= 1'b0;
    end else begin
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
      cnt_q[0]   <= cnt_d[0];
      cnt_q[1]   <= cnt_d[1];
      last_tx_q  <= last_tx_d;
      claim_v_q  <= claim_v_d;
      claim_id_q <= claim_id_d;
      tx_clear_q <= tx_clear_d;
    end
  end

  // irq_o is decoded purely from the state registers.
  assign bus.irq_o      = in_pend[0] | in_pend[1];
  assign bus.claim_v_o  = claim_v_q;
  assign bus.claim_id_o = claim_id_q;
  assign bus.tx_clear_o = tx_clear_q;

endmodule

// File: tb/tb_eth_irq_claim_gateway.sv
// Bench for eth_irq_claim_gateway: directed scenarios with literal expectations
// followed by randomized traffic, all outputs compared every cycle to a model.
module tb_eth_irq_claim_gateway;

  localparam int H = 16;

  logic clk_i     = 1'b0;
  logic reset_n_i = 1'b1;

  eth_irq_claim_gateway_if bus_if ();

  eth_irq_claim_gateway #(.holdoff_cycles_p(H)) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .bus       (bus_if)
  );

  initial forever #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A source is either claimed by the host, or free; a free source mirrors its
  // pending input once the cycle count has reached its release point.
  int       cyc          = 0;
  bit       m_pend    [2] = '{0, 0};
  bit       m_claimed [2] = '{0, 0};
  int       m_release [2] = '{0, 0};
  bit       m_last_tx    = 1'b1;
  bit       m_cv         = 1'b0;
  int       m_id         = 0;
  bit       m_clr        = 1'b0;
  int       m_grant;
  bit       m_pin     [2];

  always @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cyc = 0;
      for (int i = 0; i < 2; i++) begin
        m_pend[i] = 0; m_claimed[i] = 0; m_release[i] = 0;
      end
      m_last_tx = 1; m_cv = 0; m_id = 0; m_clr = 0;
    end else begin
      cyc++;
      m_pin[0] = bus_if.rx_pending_i;
      m_pin[1] = bus_if.tx_pending_i;
      m_grant = -1;
      if (bus_if.claim_v_i) begin
        if (m_pend[0] && m_pend[1]) m_grant = m_last_tx ? 0 : 1;
        else if (m_pend[0])         m_grant = 0;
        else if (m_pend[1])         m_grant = 1;
      end
      m_cv  = bus_if.claim_v_i;
      m_id  = (m_grant < 0) ? 0 : m_grant + 1;
      m_clr = (m_grant == 1);
      if (m_grant >= 0) m_last_tx = (m_grant == 1);
      for (int i = 0; i < 2; i++) begin
        if (m_grant == i) begin
          m_pend[i] = 0; m_claimed[i] = 1;
        end else if (m_claimed[i]) begin
          if (bus_if.complete_v_i && int'(bus_if.complete_id_i) == i + 1) begin
            m_claimed[i] = 0;
            m_release[i] = cyc + H + 1;
          end
        end else if (cyc >= m_release[i]) begin
          m_pend[i] = m_pin[i];
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  bit cmp_en = 1'b0;
  always @(negedge clk_i) begin
    if (cmp_en) begin
      check("irq_o",      int'(bus_if.irq_o),      int'(m_pend[0] | m_pend[1]));
      check("claim_v_o",  int'(bus_if.claim_v_o),  int'(m_cv));
      check("claim_id_o", int'(bus_if.claim_id_o), m_id);
      check("tx_clear_o", int'(bus_if.tx_clear_o), int'(m_clr));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic claim();
    bus_if.claim_v_i = 1'b1;
    tick();
    bus_if.claim_v_i = 1'b0;
  endtask

  task automatic complete(input logic [1:0] id);
    bus_if.complete_v_i  = 1'b1;
    bus_if.complete_id_i = id;
    tick();
    bus_if.complete_v_i  = 1'b0;
    bus_if.complete_id_i = 2'd0;
  endtask

  initial begin
    int r;
    bus_if.rx_pending_i  = 1'b0;
    bus_if.tx_pending_i  = 1'b0;
    bus_if.claim_v_i     = 1'b0;
    bus_if.complete_v_i  = 1'b0;
    bus_if.complete_id_i = 2'd0;
    #2 reset_n_i = 1'b0;
    cmp_en = 1'b1;

    // Reset held: inputs wiggle, outputs stay 0.
    for (int n = 0; n < 6; n++) begin
      bus_if.rx_pending_i  = n[0];
      bus_if.tx_pending_i  = n[1];
      bus_if.claim_v_i     = 1'b1;
      bus_if.complete_v_i  = 1'b1;
      bus_if.complete_id_i = n[1:0];
      tick();
    end
    check("rst_irq", int'(bus_if.irq_o), 0);
    check("rst_claim_v", int'(bus_if.claim_v_o), 0);
    bus_if.rx_pending_i = 0; bus_if.tx_pending_i = 0;
    bus_if.claim_v_i = 0; bus_if.complete_v_i = 0; bus_if.complete_id_i = 0;
    reset_n_i = 1'b1;
    repeat (3) tick();
    check("idle_irq", int'(bus_if.irq_o), 0);

    // RX single with 16-cycle holdoff.
    bus_if.rx_pending_i = 1'b1;
    tick();
    check("rx_irq", int'(bus_if.irq_o), 1);
    claim();
    check("rx_claim_v", int'(bus_if.claim_v_o), 1);
    check("rx_claim_id", int'(bus_if.claim_id_o), 1);
    check("rx_no_clear", int'(bus_if.tx_clear_o), 0);
    check("rx_irq_drop", int'(bus_if.irq_o), 0);
    complete(2'd1);
    for (int k = 1; k <= H; k++) begin
      tick();
      check("rx_holdoff", int'(bus_if.irq_o), 0);
    end
    tick();
    check("rx_reassert", int'(bus_if.irq_o), 1);
    bus_if.rx_pending_i = 1'b0;
    tick();

    // TX with clear pulse.
    bus_if.tx_pending_i = 1'b1;
    tick();
    check("tx_irq", int'(bus_if.irq_o), 1);
    claim();
    check("tx_claim_id", int'(bus_if.claim_id_o), 2);
    check("tx_clear", int'(bus_if.tx_clear_o), 1);
    bus_if.tx_pending_i = 1'b0;
    tick();
    check("tx_clear_1cyc", int'(bus_if.tx_clear_o), 0);
    check("tx_id_back0", int'(bus_if.claim_id_o), 0);
    complete(2'd2);
    repeat (20) tick();
    check("tx_no_reassert", int'(bus_if.irq_o), 0);

    // Contention: ids 1, 2, 1.
    bus_if.rx_pending_i = 1'b1;
    bus_if.tx_pending_i = 1'b1;
    tick();
    claim();
    check("cont_id_a", int'(bus_if.claim_id_o), 1);
    complete(2'd1);
    claim();
    check("cont_id_b", int'(bus_if.claim_id_o), 2);
    bus_if.tx_pending_i = 1'b0;
    complete(2'd2);
    repeat (20) tick();
    claim();
    check("cont_id_c", int'(bus_if.claim_id_o), 1);
    bus_if.rx_pending_i = 1'b0;
    complete(2'd1);
    repeat (20) tick();
    claim();
    check("empty_claim_v", int'(bus_if.claim_v_o), 1);
    check("empty_claim_id", int'(bus_if.claim_id_o), 0);

    // Bad completes leave a pending RX untouched.
    bus_if.rx_pending_i = 1'b1;
    tick();
    complete(2'd3);
    check("bad_cpl_id3", int'(bus_if.irq_o), 1);
    complete(2'd2);
    check("bad_cpl_tx_idle", int'(bus_if.irq_o), 1);
    complete(2'd1);
    check("bad_cpl_rx_pend", int'(bus_if.irq_o), 1);
    bus_if.rx_pending_i = 1'b0;
    tick();
    check("rx_drop_idle", int'(bus_if.irq_o), 0);

    // Reset during holdoff.
    bus_if.rx_pending_i = 1'b1;
    tick();
    claim();
    bus_if.tx_pending_i = 1'b1;
    complete(2'd1);
    check("hold_tx_irq", int'(bus_if.irq_o), 1);
    reset_n_i = 1'b0;
    #1;
    check("mid_rst_irq", int'(bus_if.irq_o), 0);
    repeat (2) tick();
    reset_n_i = 1'b1;
    tick();
    check("post_rst_irq", int'(bus_if.irq_o), 1);
    check("post_rst_no_pulse", int'(bus_if.claim_v_o), 0);
    // Reset during a claim response.
    claim();
    check("pre_rst_claim", int'(bus_if.claim_id_o), 1);
    reset_n_i = 1'b0;
    #1;
    check("mid_rst_claim_v", int'(bus_if.claim_v_o), 0);
    check("mid_rst_claim_id", int'(bus_if.claim_id_o), 0);
    bus_if.rx_pending_i = 1'b0;
    bus_if.tx_pending_i = 1'b0;
    tick();
    reset_n_i = 1'b1;
    tick();

    // Randomized traffic checked by the model every cycle.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 7) == 0) bus_if.rx_pending_i = ~bus_if.rx_pending_i;
      if (m_clr) bus_if.tx_pending_i = 1'b0;
      else if ($urandom_range(0, 9) == 0) bus_if.tx_pending_i = 1'b1;
      bus_if.claim_v_i    = ($urandom_range(0, 3) == 0);
      bus_if.complete_v_i = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 9);
      bus_if.complete_id_i = (r < 4) ? 2'd1 : (r < 8) ? 2'd2 : (r == 8) ? 2'd0 : 2'd3;
      reset_n_i = ($urandom_range(0, 599) != 0);
      tick();
    end
    reset_n_i = 1'b1;
    bus_if.claim_v_i = 1'b0;
    bus_if.complete_v_i = 1'b0;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eth_irq_claim_gateway.md
# eth_irq_claim_gateway

Host-side gateway for the Ethernet core's interrupt lines. It accepts the RX and TX interrupt-pending levels from the Ethernet interrupt generator and drives a single interrupt request to the host. It serves the host through a claim/complete handshake and returns the TX pending-clear pulse to the generator. Each source is masked from claim until the host completes it, followed by a programmable holdoff that coalesces interrupt storms.

## Interface
- holdoff_cycles_p, default 16: cycles a source stays masked after complete; 0 means no holdoff.
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- rx_pending_i  in  1  RX interrupt-pending level from the generator.
- tx_pending_i  in  1  TX interrupt-pending level from the generator (sticky until cleared).
- claim_v_i  in  1  host claim request, one-cycle pulse.
- complete_v_i  in  1  host completion, one-cycle pulse.
- complete_id_i  in  2  id being completed: 1 = RX, 2 = TX, other values are ignored.
- irq_o  out  1  interrupt request to the host.
- claim_v_o  out  1  claim response valid, one cycle.
- claim_id_o  out  2  claimed id: 0 = none, 1 = RX, 2 = TX.
- tx_clear_o  out  1  one-cycle clear pulse to the generator's TX pending register.

## Operation
- Each source (RX, TX) has an independent four-state FSM: IDLE, PEND, CLAIMED, HOLD.
- IDLE -> PEND when the source's pending input is 1.
- PEND -> CLAIMED when the source wins a claim.
- PEND -> IDLE when the pending input is 0 and the source is not granted that cycle. A grant takes precedence over a simultaneous drop.
- CLAIMED -> HOLD on complete_v_i with a matching complete_id_i. If holdoff_cycles_p = 0, CLAIMED -> IDLE instead.
- HOLD: the per-source counter loads holdoff_cycles_p-1 on entry and decrements each cycle. HOLD -> IDLE when the counter is 0.
- The counter width is $clog2(holdoff_cycles_p+1), with a minimum of 1.
- Pending inputs are ignored in CLAIMED and HOLD.
- irq_o = (rx_state == PEND) | (tx_state == PEND), decoded from state registers only.
- Claim arbitration uses the registered states at the cycle claim_v_i is sampled:
  - Exactly one source in PEND: that source is granted.
  - Both in PEND: the source not granted last is granted (round-robin). last_r updates on every grant.
  - Neither in PEND: claim_id_o = 0 and no state changes.
- A TX grant pulses tx_clear_o in the same cycle as claim_v_o. This clears the generator's sticky TX pending bit. RX has no clear; the host drains the RX buffer itself.
- Ignored completions: complete_id_i values 0 or 3, and completions for a source not in CLAIMED, are dropped silently.
- claim_v_i and complete_v_i in the same cycle are both processed.
  - A complete for source X and a claim in the same cycle cannot grant X, because X is not in PEND.

## Timing
- Reset values (asynchronous, while reset_n_i = 0):
  - Both FSMs IDLE, counters 0, last_r = TX (so RX wins the first contention).
  - irq_o = 0, claim_v_o = 0, claim_id_o = 0, tx_clear_o = 0.
- Reset asserted mid-operation aborts any claim or holdoff immediately. No pulses are emitted on reset release.
- pending_i rising at edge N gives PEND and irq_o = 1 after edge N. Latency is 1 cycle.
- claim_v_i sampled at edge N:
  - claim_v_o, claim_id_o, and tx_clear_o are registered and valid for exactly the one cycle after edge N.
  - The granted state becomes CLAIMED at edge N, so irq_o drops in that same cycle unless the other source is in PEND.
- complete_v_i sampled at edge N gives HOLD after N.
  - The source may re-enter PEND no earlier than edge N + holdoff_cycles_p + 1.
  - With holdoff_cycles_p = 0, it may re-enter PEND at edge N+1.
- Back-to-back claims on consecutive cycles are legal. Each is arbitrated on the updated states.
- claim_id_o returns to 0 whenever claim_v_o = 0.

## Test plan
- Reset: hold reset_n_i low, toggle all inputs -> every output 0. Release -> outputs stay 0 until a pending input is 1.
- RX single: rx_pending_i = 1 -> irq_o = 1 next cycle. claim_v_i -> claim_v_o = 1, claim_id_o = 1, tx_clear_o = 0, irq_o = 0. Complete id 1 -> with rx_pending_i held, irq_o reasserts exactly 17 cycles after complete (holdoff_cycles_p = 16).
- TX clear: tx_pending_i = 1, claim -> claim_id_o = 2 and tx_clear_o = 1 for one cycle. The model drops tx_pending_i. Complete id 2 -> no reassertion.
- Contention: both pending, three claims with completes between them -> ids 1, 2, 1. Each claim with nothing pending -> claim_id_o = 0.
- Bad completes: complete id 3, and complete id 2 while TX is IDLE -> no state change, irq_o unchanged.
- Mid-operation reset: assert reset_n_i during HOLD and during a claim response -> outputs 0 immediately. After release, a pending input reasserts irq_o after 1 cycle with no holdoff.
